transmitter: RTL and testbench

UART transmitter: the serial-output counterpart of the 8x-oversampling receiver. A parent writes bytes into a one-byte holding register (THR). The block moves each byte into a shift register (TSR) and sends it on `tx_data` as 8N1: one start bit (0), eight data bits LSB first, one stop bit (1). Bit timing comes from the shared `bclkx8` baud-rate clock, which runs at 8x the bit rate and is shared with the receiver.

---
 rtl/transmitter.sv | 136 +++++++++++++
 tb/tb_transmitter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// UART 8N1 transmitter. A one-byte holding register (THR) feeds a shift
// register (TSR). Bit timing comes from an 8x baud clock that is sampled
// on sys_clk and edge-detected into single-cycle ticks.
module transmitter (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       bclkx8,
   input  logic       tx_load,
   input  logic [7:0] tx_din,
   output logic       tx_data,
   output logic       tdre,
   output logic       tx_busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q, state_d;
   logic [7:0]  thr_q, thr_d;
   logic [7:0]  tsr_q, tsr_d;
   logic [2:0]  count_q, count_d;
   logic [3:0]  bit_count_q, bit_count_d;
   logic        tdre_q, tdre_d;
   logic        tx_data_q, tx_data_d;
   logic        bclkx8_old_q;
   logic        tick;

   // Baud-clock history. It follows bclkx8 every cycle, including while reset
   // is held, so it already equals bclkx8 at release and no false tick occurs.
   always_ff @(posedge sys_clk) begin
      bclkx8_old_q <= bclkx8;
   end

   assign tick = bclkx8 & ~bclkx8_old_q;

   // Next-state logic: THR write handling plus the frame FSM, advancing on ticks.
   always_comb begin
      state_d     = state_q;
      thr_d       = thr_q;
      tsr_d       = tsr_q;
      count_d     = count_q;
      bit_count_d = bit_count_q;
      tdre_d      = tdre_q;
      tx_data_d   = tx_data_q;

      // A write is accepted only while THR is empty; otherwise the byte is dropped.
      // A THR->TSR transfer needs tdre=0, so it can never collide with this.
      if (tx_load && tdre_q) begin
         thr_d  = tx_din;
         tdre_d = 1'b0;
      end

      if (tick) begin
         case (state_q)
            IDLE: begin
               tx_data_d = 1'b1;
               if (!tdre_q) begin
                  tsr_d     = thr_q;
                  tdre_d    = 1'b1;
                  tx_data_d = 1'b0;
                  count_d   = 3'd0;
                  state_d   = START;
               end
            end
            START: begin
               if (count_q == 3'd7) begin
                  tx_data_d   = tsr_q[0];
                  tsr_d       = {1'b0, tsr_q[7:1]};
                  bit_count_d = 4'd1;
                  count_d     = 3'd0;
                  state_d     = DATA;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
            DATA: begin
               if (count_q == 3'd7) begin
                  if (bit_count_q == 4'd8) begin
                     tx_data_d = 1'b1;
                     state_d   = STOP;
                  end else begin
                     tx_data_d   = tsr_q[0];
                     tsr_d       = {1'b0, tsr_q[7:1]};
                     bit_count_d = bit_count_q + 4'd1;
                  end
                  count_d = 3'd0;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
            STOP: begin
               if (count_q == 3'd7) begin
                  count_d = 3'd0;
                  if (!tdre_q) begin
                     // Next byte already waiting: start bit follows the stop bit directly.
                     tsr_d     = thr_q;
                     tdre_d    = 1'b1;
                     tx_data_d = 1'b0;
                     state_d   = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; reset forces the line high at once and drops any held byte.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         thr_q       <= 8'd0;
         tsr_q       <= 8'd0;
         count_q     <= 3'd0;
         bit_count_q <= 4'd0;
         tdre_q      <= 1'b1;
         tx_data_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         thr_q       <= thr_d;
         tsr_q       <= tsr_d;
         count_q     <= count_d;
         bit_count_q <= bit_count_d;
         tdre_q      <= tdre_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign tx_data = tx_data_q;
   assign tdre    = tdre_q;
   assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for the UART transmitter: stimulus pushes expected bytes,
// a monitor decodes the line tick by tick and compares every cycle.
module tb_transmitter;

   logic       sys_clk = 1'b0;
   logic       rst;
   logic       bclkx8;
   logic       tx_load;
   logic [7:0] tx_din;
   logic       tx_data;
   logic       tdre;
   logic       tx_busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic       in_frame = 1'b0;
   int         k = 0;
   logic [9:0] fb = '0;
   logic       bclk_en = 1'b0;
   logic [1:0] phase = 2'd3;

   transmitter dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bclkx8  (bclkx8),
      .tx_load (tx_load),
      .tx_din  (tx_din),
      .tx_data (tx_data),
      .tdre    (tdre),
      .tx_busy (tx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Baud clock: 4 sys_clk cycles per period (2 high, 2 low), pausable.
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (bclk_en) begin
            phase = phase + 2'd1;
            bclkx8 = phase[1];
         end
      end
   end

   // Monitor: tracks ticks, follows each frame bit by bit, checks every cycle.
   initial begin
      logic prev;
      logic t;
      prev = 1'b0;
      forever begin
         @(posedge sys_clk);
         t = bclkx8 & ~prev;
         prev = bclkx8;
         @(negedge sys_clk);
         if (rst) begin
            in_frame = 1'b0;
            k = 0;
         end else begin
            if (in_frame && t) begin
               k++;
               if (k == 80) begin
                  in_frame = 1'b0;
                  check("frame_complete", 1, 1 - int'(tx_busy === 1'bx));
               end
            end
            if (in_frame) begin
               check("line_bit", int'(tx_data), int'(fb[k/8]));
               check("busy_in_frame", int'(tx_busy), 1);
            end else if (tx_data == 1'b0) begin
               check("start_on_tick", int'(t), 1);
               check("start_expected", int'(exp_q.size() > 0), 1);
               check("tdre_at_start", int'(tdre), 1);
               if (exp_q.size() > 0) begin
                  fb = {1'b1, exp_q.pop_front(), 1'b0};
                  $display("frame start byte=%02h at %0t", fb[8:1], $time);
               end else begin
                  fb = 10'h3ff;
               end
               in_frame = 1'b1;
               k = 0;
               check("busy_at_start", int'(tx_busy), 1);
            end else begin
               check("idle_line", int'(tx_data), 1);
               check("idle_busy", int'(tx_busy), 0);
            end
         end
      end
   end

   task automatic load(input logic [7:0] b);
      @(posedge sys_clk);
      #1;
      tx_load = 1'b1;
      tx_din = b;
      @(posedge sys_clk);
      #1;
      tx_load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, int'(n < 3000), 1);
      @(negedge sys_clk);
   endtask

   task automatic wait_tdre(input string name);
      int n;
      n = 0;
      while (tdre != 1'b1 && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, int'(n < 500), 1);
   endtask

   task automatic wait_k(input int kmin, input string name);
      int n;
      n = 0;
      while (!(in_frame && k >= kmin) && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, int'(n < 2000), 1);
   endtask

   initial begin
      rst = 1'b1;
      bclkx8 = 1'b1;
      tx_load = 1'b0;
      tx_din = 8'h00;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("reset_tx_data", int'(tx_data), 1);
      check("reset_tdre", int'(tdre), 1);
      check("reset_busy", int'(tx_busy), 0);

      // Release reset with bclkx8 high and frozen: no tick may occur.
      @(posedge sys_clk);
      #1 rst = 1'b0;
      exp_q.push_back(8'hA5);
      load(8'hA5);
      @(negedge sys_clk);
      check("tdre_after_load", int'(tdre), 0);
      repeat (10) @(negedge sys_clk);
      check("no_tick_tdre_hold", int'(tdre), 0);
      check("no_tick_line_hold", int'(tx_data), 1);
      bclk_en = 1'b1;
      wait_idle("a5_done");
      check("a5_tdre_end", int'(tdre), 1);
      check("a5_busy_end", int'(tx_busy), 0);
      $display("single byte A5 done");

      // Back-to-back: 0x0F loaded during 0x55 data bits.
      exp_q.push_back(8'h55);
      load(8'h55);
      wait_tdre("b2b_transfer");
      wait_k(20, "b2b_reach_data");
      exp_q.push_back(8'h0F);
      load(8'h0F);
      @(negedge sys_clk);
      check("b2b_tdre_held", int'(tdre), 0);
      wait_idle("b2b_done");
      $display("back-to-back 55,0F done");

      // Overrun: 0x33 arrives while THR still holds 0x22 and is dropped.
      exp_q.push_back(8'h11);
      load(8'h11);
      wait_tdre("ovr_transfer");
      exp_q.push_back(8'h22);
      @(posedge sys_clk);
      #1 tx_load = 1'b1; tx_din = 8'h22;
      @(posedge sys_clk);
      #1 tx_din = 8'h33;
      @(posedge sys_clk);
      #1 tx_load = 1'b0;
      @(negedge sys_clk);
      check("ovr_tdre_full", int'(tdre), 0);
      wait_idle("ovr_done");
      $display("overrun 11,22 (33 dropped) done");

      // Reset during data bit 3 of 0x3C.
      exp_q.push_back(8'h3C);
      load(8'h3C);
      wait_k(34, "rst_reach_bit3");
      @(posedge sys_clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_tx_data", int'(tx_data), 1);
      check("midrst_tdre", int'(tdre), 1);
      check("midrst_busy", int'(tx_busy), 0);
      @(posedge sys_clk);
      #1 rst = 1'b0;
      repeat (400) @(negedge sys_clk);
      check("post_rst_busy", int'(tx_busy), 0);
      check("post_rst_tdre", int'(tdre), 1);
      $display("mid-frame reset done");

      // Freeze the baud clock mid-frame for 50 cycles.
      exp_q.push_back(8'h96);
      load(8'h96);
      wait_k(20, "frz_reach");
      bclk_en = 1'b0;
      repeat (50) @(negedge sys_clk);
      check("frz_busy", int'(tx_busy), 1);
      bclk_en = 1'b1;
      wait_idle("frz_done");
      $display("freeze 96 done");

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
